// File: rtl/muldiv_seq_pkg.sv
// Shared types and opcode decode helpers for the divide sequencer.
// Opcode bit layout: [2]=word, [1]=remainder, [0]=unsigned.
package muldiv_seq_pkg;

   typedef enum logic [2:0] {
      OP_DIV   = 3'd0,
      OP_DIVU  = 3'd1,
      OP_REM   = 3'd2,
      OP_REMU  = 3'd3,
      OP_DIVW  = 3'd4,
      OP_DIVUW = 3'd5,
      OP_REMW  = 3'd6,
      OP_REMUW = 3'd7
   } divop_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   function automatic logic is_word(divop_t op);
      return op[2];
   endfunction

   function automatic logic is_signed(divop_t op);
      return ~op[0];
   endfunction

   function automatic logic is_rem(divop_t op);
      return op[1];
   endfunction

endpackage

// File: rtl/muldiv_seq_div_step.sv
// One radix-2 restoring division iteration on unsigned magnitudes.
// Purely combinational; the caller registers the outputs.
module div_step #(
   parameter int XLEN = 64
) (
   input  logic [XLEN-1:0] remIn,
   input  logic [XLEN-1:0] shiftIn,
   input  logic [XLEN-1:0] divisor,
   output logic [XLEN-1:0] remOut,
   output logic [XLEN-1:0] shiftOut,
   output logic            qBit
);

   logic [XLEN:0] partial;
   logic [XLEN:0] diff;

   assign partial = {remIn, shiftIn[XLEN-1]};
   assign diff    = partial - {1'b0, divisor};

   // remIn < divisor keeps partial < 2*divisor, so the top bit of diff is a clean borrow.
   assign qBit     = ~diff[XLEN];
   assign remOut   = qBit ? diff[XLEN-1:0] : partial[XLEN-1:0];
   assign shiftOut = {shiftIn[XLEN-2:0], qBit};

endmodule

// File: rtl/muldiv_seq.sv
// RV64M divide/remainder sequencer: restoring division, one bit per cycle, stalls the pipe while busy.
// Divide-by-zero and signed overflow resolve at accept and go straight to DONE.
module muldiv_seq
   import muldiv_seq_pkg::*;
#(
   parameter int XLEN  = 64,
   parameter int CNT_W = 7
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            valid_i,
   input  logic [2:0]      op_i,
   input  logic [XLEN-1:0] a_i,
   input  logic [XLEN-1:0] b_i,
   input  logic            flush_i,
   output logic            stall_o,
   output logic            done_o,
   output logic [XLEN-1:0] result_o
);

   localparam logic [XLEN-1:0] MIN_D = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [XLEN-1:0] MIN_W = {{(XLEN-31){1'b1}}, {31{1'b0}}};

   state_t           state, nextState;
   logic [CNT_W-1:0] count;
   logic [XLEN-1:0]  remReg, shiftReg, divisorReg, resultReg;
   logic             wordReg, remSelReg, negQReg, negRReg;

   divop_t          opIn;
   logic            wordIn, signedIn, remSelIn, accept;
   logic [XLEN-1:0] opA, opB, magA, magB, specialRaw;
   logic            aNeg, bNeg, divZero, overflow, special;

   logic [XLEN-1:0]  stepRem, stepShift, qFinal, rFinal, busyRaw;
   logic [CNT_W-1:0] lastCount;
   logic             lastStep, stepQBit;

   function automatic logic [XLEN-1:0] wordExt(logic [XLEN-1:0] v, logic word);
      return word ? {{(XLEN-32){v[31]}}, v[31:0]} : v;
   endfunction

   // Accept-side operand preparation
   assign opIn     = divop_t'(op_i);
   assign wordIn   = is_word(opIn);
   assign signedIn = is_signed(opIn);
   assign remSelIn = is_rem(opIn);
   assign accept   = (state == S_IDLE) && valid_i && !flush_i;

   assign opA = wordIn ? {{(XLEN-32){signedIn & a_i[31]}}, a_i[31:0]} : a_i;
   assign opB = wordIn ? {{(XLEN-32){signedIn & b_i[31]}}, b_i[31:0]} : b_i;

   assign aNeg = signedIn & opA[XLEN-1];
   assign bNeg = signedIn & opB[XLEN-1];
   assign magA = aNeg ? -opA : opA;
   assign magB = bNeg ? -opB : opB;

   assign divZero  = (opB == '0);
   assign overflow = signedIn && (opB == '1) && (opA == (wordIn ? MIN_W : MIN_D));
   assign special  = divZero | overflow;

   always_comb begin
      specialRaw = '0;
      if (divZero)
         specialRaw = remSelIn ? opA : '1;
      else
         specialRaw = remSelIn ? '0 : opA;
   end

   div_step #(.XLEN(XLEN)) uStep (
      .remIn   (remReg),
      .shiftIn (shiftReg),
      .divisor (divisorReg),
      .remOut  (stepRem),
      .shiftOut(stepShift),
      .qBit    (stepQBit)
   );

   assign lastCount = wordReg ? CNT_W'(31) : CNT_W'(XLEN-1);
   assign lastStep  = (count == lastCount);
   assign qFinal    = negQReg ? -stepShift : stepShift;
   assign rFinal    = negRReg ? -stepRem : stepRem;
   assign busyRaw   = remSelReg ? rFinal : qFinal;

   always_comb begin
      nextState = state;
      stall_o   = 1'b0;
      done_o    = 1'b0;
      case (state)
         S_IDLE: begin
            stall_o = accept;
            if (accept)
               nextState = special ? S_DONE : S_BUSY;
         end
         S_BUSY: begin
            stall_o = 1'b1;
            if (lastStep)
               nextState = S_DONE;
         end
         S_DONE: begin
            done_o    = 1'b1;
            nextState = S_IDLE;
         end
         default: nextState = S_IDLE;
      endcase
      if (flush_i) begin
         nextState = S_IDLE;
         done_o    = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         count      <= '0;
         remReg     <= '0;
         shiftReg   <= '0;
         divisorReg <= '0;
         resultReg  <= '0;
         wordReg    <= 1'b0;
         remSelReg  <= 1'b0;
         negQReg    <= 1'b0;
         negRReg    <= 1'b0;
      end else begin
         state <= nextState;
         if (accept) begin
            count      <= '0;
            remReg     <= '0;
            // W dividends start in the upper half so their bits reach the MSB first
            shiftReg   <= wordIn ? (magA << 32) : magA;
            divisorReg <= magB;
            wordReg    <= wordIn;
            remSelReg  <= remSelIn;
            negQReg    <= aNeg ^ bNeg;
            negRReg    <= aNeg;
            if (special)
               resultReg <= wordExt(specialRaw, wordIn);
         end else if (state == S_BUSY && !flush_i) begin
            remReg   <= stepRem;
            shiftReg <= stepShift;
            count    <= count + 1'b1;
            if (lastStep)
               resultReg <= wordExt(busyRaw, wordReg);
         end
      end
   end

   assign result_o = resultReg;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed RISC-V corner cases plus random ops vs an arithmetic model.
module tb_muldiv_seq;
   import muldiv_seq_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        valid_i;
   logic [2:0]  op_i;
   logic [63:0] a_i, b_i;
   logic        flush_i;
   logic        stall_o, done_o;
   logic [63:0] result_o;

   int checks   = 0;
   int failures = 0;

   muldiv_seq #(.XLEN(64), .CNT_W(7)) dut (
      .clk     (clk),
      .reset   (reset),
      .valid_i (valid_i),
      .op_i    (op_i),
      .a_i     (a_i),
      .b_i     (b_i),
      .flush_i (flush_i),
      .stall_o (stall_o),
      .done_o  (done_o),
      .result_o(result_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Reference: RISC-V M-extension division semantics with plain language arithmetic
   task automatic refModel(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                           output logic [63:0] res, output bit special);
      bit word, sgn, rem;
      {word, sgn, rem} = 3'b000;
      case (divop_t'(op))
         OP_DIV:   {word, sgn, rem} = 3'b010;
         OP_DIVU:  {word, sgn, rem} = 3'b000;
         OP_REM:   {word, sgn, rem} = 3'b011;
         OP_REMU:  {word, sgn, rem} = 3'b001;
         OP_DIVW:  {word, sgn, rem} = 3'b110;
         OP_DIVUW: {word, sgn, rem} = 3'b100;
         OP_REMW:  {word, sgn, rem} = 3'b111;
         OP_REMUW: {word, sgn, rem} = 3'b101;
         default:  {word, sgn, rem} = 3'b000;
      endcase
      if (word) begin
         logic signed [31:0] sa32, sb32;
         logic [31:0] ua32, ub32, q32, r32;
         sa32 = a[31:0]; sb32 = b[31:0]; ua32 = a[31:0]; ub32 = b[31:0];
         special = 1'b0;
         if (ub32 == 0) begin
            q32 = '1; r32 = ua32; special = 1'b1;
         end else if (sgn && sa32 == 32'sh8000_0000 && sb32 == -1) begin
            q32 = ua32; r32 = '0; special = 1'b1;
         end else if (sgn) begin
            q32 = sa32 / sb32; r32 = sa32 % sb32;
         end else begin
            q32 = ua32 / ub32; r32 = ua32 % ub32;
         end
         res = rem ? {{32{r32[31]}}, r32} : {{32{q32[31]}}, q32};
      end else begin
         logic signed [63:0] sa64, sb64;
         logic [63:0] q64, r64;
         sa64 = a; sb64 = b;
         special = 1'b0;
         if (b == 0) begin
            q64 = '1; r64 = a; special = 1'b1;
         end else if (sgn && a == 64'h8000_0000_0000_0000 && sb64 == -1) begin
            q64 = a; r64 = '0; special = 1'b1;
         end else if (sgn) begin
            q64 = sa64 / sb64; r64 = sa64 % sb64;
         end else begin
            q64 = a / b; r64 = a % b;
         end
         res = rem ? r64 : q64;
      end
   endtask

   // Present one op in cycle 0, then watch for done_o within a bounded window
   task automatic doOp(input string tag, input logic [2:0] op, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] expRes, input int expLat);
      int doneCyc;
      int badStall;
      logic [63:0] got;
      doneCyc  = -1;
      badStall = 0;
      got      = 'x;
      @(negedge clk);
      valid_i = 1'b1; op_i = op; a_i = a; b_i = b;
      #1;
      chk({tag, "_stall0"}, 64'(stall_o), 64'd1);
      @(posedge clk);
      #1 valid_i = 1'b0;
      for (int c = 1; c <= 100 && doneCyc < 0; c++) begin
         @(negedge clk);
         if (done_o) begin
            doneCyc = c;
            got     = result_o;
            chk({tag, "_stallDone"}, 64'(stall_o), 64'd0);
         end else if (!stall_o) begin
            badStall++;
         end
      end
      chk({tag, "_lat"}, 64'(doneCyc), 64'(expLat));
      chk({tag, "_res"}, got, expRes);
      chk({tag, "_busyStall"}, 64'(badStall), 64'd0);
      @(negedge clk);
      chk({tag, "_pulse"}, 64'(done_o), 64'd0);
   endtask

   // Start an op, disturb it at the given cycle, then require silence afterwards
   task automatic abortOp(input string tag, input bit useReset, input int atCyc);
      int doneSeen;
      doneSeen = 0;
      @(negedge clk);
      valid_i = 1'b1; op_i = OP_DIV; a_i = 64'd100; b_i = 64'd7;
      @(posedge clk);
      #1 valid_i = 1'b0;
      for (int c = 1; c < atCyc; c++) begin
         @(negedge clk);
         if (done_o) doneSeen++;
      end
      @(negedge clk);
      if (useReset) reset = 1'b1;
      else          flush_i = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0; flush_i = 1'b0;
      @(negedge clk);
      chk({tag, "_stallAfter"}, 64'(stall_o), 64'd0);
      chk({tag, "_doneAfter"}, 64'(done_o), 64'd0);
      if (useReset) chk({tag, "_resAfter"}, result_o, 64'd0);
      for (int c = 0; c < 80; c++) begin
         @(negedge clk);
         if (done_o) doneSeen++;
      end
      chk({tag, "_noDone"}, 64'(doneSeen), 64'd0);
   endtask

   initial begin
      logic [63:0] ra, rb, rres;
      logic [2:0]  rop;
      bit          rspec;
      int          mode;

      reset = 1'b1; valid_i = 1'b0; op_i = '0; a_i = '0; b_i = '0; flush_i = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("rst_done", 64'(done_o), 64'd0);
      chk("rst_stall", 64'(stall_o), 64'd0);
      chk("rst_res", result_o, 64'd0);

      doOp("div100_7",  OP_DIV,  64'd100, 64'd7, 64'd14, 65);
      doOp("rem100_7",  OP_REM,  64'd100, 64'd7, 64'd2, 65);
      doOp("divm7_2",   OP_DIV,  -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65);
      doOp("remm7_2",   OP_REM,  -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65);
      doOp("remu7_2",   OP_REMU, 64'd7, 64'd2, 64'd1, 65);
      doOp("divuZero",  OP_DIVU, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
      doOp("remZero",   OP_REM,  64'h1234, 64'd0, 64'h1234, 1);
      doOp("divOvf",    OP_DIV,  64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
           64'h8000_0000_0000_0000, 1);
      doOp("divwOvf",   OP_DIVW, 64'h0000_0001_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
           64'hFFFF_FFFF_8000_0000, 1);
      doOp("divuw",     OP_DIVUW, 64'hFFFF_FFFF_0000_0010, 64'd4, 64'd4, 33);

      abortOp("flush", 1'b0, 10);
      doOp("div9_3", OP_DIV, 64'd9, 64'd3, 64'd3, 65);
      abortOp("rstBusy", 1'b1, 20);

      for (int i = 0; i < 40; i++) begin
         rop  = 3'($urandom_range(0, 7));
         mode = $urandom_range(0, 5);
         ra   = {$urandom, $urandom};
         rb   = {$urandom, $urandom};
         case (mode)
            0: rb = {$urandom, 32'd0} & (rop[2] ? 64'hFFFF_FFFF_0000_0000 : 64'd0);
            1: begin
               rb = '1;
               ra = rop[2] ? {$urandom, 32'h8000_0000} : 64'h8000_0000_0000_0000;
            end
            2: rb = 64'($urandom_range(1, 20)) * ($urandom_range(0, 1) ? 64'd1 : -64'sd1);
            3: ra = 64'($urandom_range(0, 1000));
            default: ;
         endcase
         refModel(rop, ra, rb, rres, rspec);
         doOp($sformatf("rnd%0d", i), rop, ra, rb, rres,
              rspec ? 1 : (rop[2] ? 33 : 65));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Multi-cycle RV64M divide/remainder sequencer beside the single-cycle ALU in the execute stage.
- Accepts one divide-class operation from the execute stage and runs a radix-2 restoring division over 64 or 32 iterations.
- Holds the pipeline via stall_o until the result is ready.
- Handles RISC-V special cases (divide-by-zero, signed overflow) without iterating.

Parameters:
- XLEN, 64, operand/result width.
- CNT_W, 7, iteration counter width; must hold XLEN.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- valid_i  in  1  execute stage presents a divide-class op this cycle.
- op_i  in  3  divop_t: DIV, DIVU, REM, REMU, DIVW, DIVUW, REMW, REMUW.
- a_i  in  XLEN  dividend (rs1).
- b_i  in  XLEN  divisor (rs2).
- flush_i  in  1  abort any op in flight (branch/exception kill).
- stall_o  out  1  hold the fetch/decode/execute pipeline registers.
- done_o  out  1  result_o valid; one-cycle pulse.
- result_o  out  XLEN  quotient or remainder, final (signs and W-extension applied).

Behaviour:
- States: IDLE, BUSY, DONE; state_t is 2 bits.
- Reset (synchronous, active-high):
  - state=IDLE, counter=0, quotient/remainder registers=0.
  - done_o=0, result_o=0, stall_o=0.
  - Reset mid-BUSY aborts with no done_o.
- Accept: in IDLE with valid_i=1 and flush_i=0, latch op and operands at the rising edge.
- Operand preparation:
  - W ops take the low 32 bits, sign-extended (signed ops) or zero-extended (unsigned ops).
  - Signed ops convert operands to magnitudes and record quotient and remainder signs.
  - N = 32 for W ops, 64 otherwise.
- Special cases, detected at accept and bypassing BUSY (IDLE->DONE):
  - Divisor == 0: quotient = all ones; remainder = dividend (W-extended).
  - Signed overflow (dividend == most-negative value, divisor == -1, width-appropriate): quotient = dividend; remainder = 0.
- BUSY:
  - One restoring step per cycle: shift the remainder:dividend pair left by 1, trial-subtract, set the quotient bit.
  - The counter increments from 0; leave for DONE after step N-1 (counter == N-1).
- DONE:
  - done_o=1 for exactly one cycle.
  - result_o = sign-corrected quotient or remainder; W results are sign-extended from bit 31.
  - Next state is IDLE unconditionally; valid_i in DONE is ignored.
- Latency (accept edge = cycle 0):
  - Normal: done_o high in cycle N+1 (65 for 64-bit ops, 33 for W ops).
  - Special case: done_o high in cycle 1.
- stall_o (combinational):
  - 1 when (IDLE and valid_i and !flush_i) or BUSY.
  - 0 in DONE, so upstream advances in the done_o cycle.
- result_o holds its last value outside DONE; consumers qualify it with done_o.
- flush_i:
  - In any state, the next state is IDLE; done_o is forced to 0 in the same cycle.
  - flush_i together with valid_i in IDLE: no accept.
- Back-to-back ops: a new op is accepted no earlier than the cycle after DONE.

Decomposition:
- pipes package:
  - divop_t enum (3 bits).
  - state_t for this FSM.
  - is_word(op), is_signed(op) and is_rem(op) helper functions.
- Sub-module div_step (combinational): one restoring iteration.
  - Inputs: remainder, dividend-shift, divisor.
  - Outputs: next remainder, next shift, quotient bit.
  - Instantiated once inside muldiv_seq.

Test Plan:
- DIV 100/7 -> done_o in cycle 65, result 14; stall_o=1 in cycles 0-64; REM 100/7 -> 2.
- DIV -7/2 -> 0xFFFF_FFFF_FFFF_FFFD (-3); REM -7/2 -> 0xFFFF_FFFF_FFFF_FFFF (-1); REMU 7/2 -> 1.
- DIVU 0x1234/0 -> done_o in cycle 1, result all ones; REM 0x1234/0 -> 0x1234.
- DIV 0x8000_0000_0000_0000 / -1 -> 0x8000_0000_0000_0000 in cycle 1.
- DIVW a=0x0000_0001_8000_0000, b=-1 -> 0xFFFF_FFFF_8000_0000 in cycle 1.
- DIVUW a=0xFFFF_FFFF_0000_0010, b=4 -> 4 in cycle 33.
- DIV 100/7 with flush_i pulsed at cycle 10 -> IDLE at cycle 11, no done_o.
- Next DIV 9/3 -> 3 in cycle 65 after its accept.
- reset asserted at cycle 20 of BUSY -> all outputs 0 next cycle, no done_o.
